// File: rtl/dec_rr_arbiter_pkg.sv
// dec_rr_arbiter_pkg: shared sizes, FSM encoding and one-hot helper for the decoder arbiter
package dec_rr_arbiter_pkg;
  localparam int NREQ = 8;
  localparam int IDXW = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_e;
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot = NREQ'(1) << idx;
  endfunction
endpackage

// File: rtl/dec_rr_arbiter_pick.sv
// rr_pick8: rotating priority encoder, first requester after ptr wins, ptr itself is last
module rr_pick8
  import dec_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  // scan farthest to nearest so the nearest requester after ptr is the last write
  always_comb begin
    idx = ptr;
    any = |req;
    for (int k = NREQ; k >= 1; k--)
      if (req[ptr + IDXW'(k)]) idx = ptr + IDXW'(k);
  end
endmodule

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: break-before-make round-robin owner select for a shared dec3to8.
// Optional per-owner hold limit enabled by defining DEC_ARB_TIMEOUT_EN.
module dec_rr_arbiter
  import dec_rr_arbiter_pkg::*;
#(
  parameter int MAXHOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            rel,
  output logic [IDXW-1:0] sel,
  output logic            en,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            tout
);
  if (MAXHOLD < 2 || MAXHOLD > 255) begin : g_bad_maxhold
    $error("MAXHOLD must be within 2..255");
  end
  state_e          state_q, state_d;
  logic [IDXW-1:0] sel_q, sel_d, ptr_q, ptr_d, idx;
  logic [NREQ-1:0] gnt_q;
  logic            en_q, en_d, tout_q, tout_d, any, keep, expire;
  rr_pick8 u_pick (
    .req(req),
    .ptr(ptr_q),
    .idx(idx),
    .any(any)
  );
  assign keep = req[sel_q] && !rel;
`ifdef DEC_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  // counter sits at zero outside GRANT, so it is already cleared on GRANT entry
  assign hold_d = state_q == GRANT ? hold_q + 8'd1 : 8'd0;
  assign expire = state_q == GRANT && req[sel_q] && hold_q == 8'(MAXHOLD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_q <= 8'd0;
    else hold_q <= hold_d;
`else
  assign expire = 1'b0;
`endif
  // IDLE and GAP arbitrate identically; GRANT only holds or drops to GAP
  always_comb begin
    state_d = any ? GRANT : IDLE;
    sel_d   = any ? idx : sel_q;
    ptr_d   = any ? idx : ptr_q;
    en_d    = any;
    tout_d  = 1'b0;
    if (state_q == GRANT) begin
      state_d = keep && !expire ? GRANT : GAP;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      en_d    = keep && !expire;
      tout_d  = expire;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= IDXW'(NREQ - 1);
      en_q    <= 1'b0;
      gnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      gnt_q   <= en_d ? onehot(sel_d) : '0;
      tout_q  <= tout_d;
    end
  assign sel  = sel_q;
  assign en   = en_q;
  assign gnt  = gnt_q;
  assign busy = state_q != IDLE;
  assign tout = tout_q;
endmodule
